macc_stream_acc: RTL and testbench

//  Parametrised streaming multiply-accumulate engine, successor to the fixed 8-bit macc.
//  - Each beat: NUM_INPUTS element-wise products are summed by a pipelined adder tree.
//  - Beat sums are accumulated across a vector of any length; i_last marks the final beat.
//  - Result is a saturated ACC_WIDTH dot product with an overflow flag and a beat count.
//  - Feeds the requantise/activation stage of the conv datapath; sits where macc does today.

---
 rtl/macc_stream_acc_pkg.sv | 34 +++
 rtl/macc_stream_acc_adder_tree.sv | 72 +++++++
 rtl/macc_stream_acc.sv | 176 +++++++++++++++++
 tb/tb_macc_stream_acc.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/macc_stream_acc_pkg.sv
// Shared definitions for the streaming multiply-accumulate engine.
// Provides the accumulator state encoding and elaboration-time width helpers.
// No logic lives here; everything is constant-folded at elaboration.
package macc_stream_acc_pkg;

    typedef enum logic {
        ACC_IDLE = 1'b0,   // accumulator empty, next beat opens a vector
        ACC_OPEN = 1'b1    // vector in progress, accumulator holds a partial sum
    } acc_state_t;

    // Ceiling log2, with clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Width of the summed products of one beat: product width plus tree growth.
    function automatic int tree_width(input int data_width, input int num_inputs);
        return 2 * data_width + clog2(num_inputs);
    endfunction

    // Cycles from a beat being presented to its result pulse.
    function automatic int pipe_latency(input int num_inputs);
        return clog2(num_inputs) + 2;
    endfunction

endpackage

// File: rtl/macc_stream_acc_adder_tree.sv
// Purpose: pipelined binary adder tree summing NUM_INPUTS operands, valid/last sideband.
// Latency: clog2(NUM_INPUTS) cycles, one registered layer per tree level.
// Backpressure: none; a new set of operands may enter every cycle.
// Ports: clk, rst_n (sync, active-low, clears sideband only), data (packed operands),
//        valid/last in, sum (DATA_WIDTH+L bits), sum_valid/sum_last out.
module macc_stream_acc_adder_tree
    import macc_stream_acc_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 16,
    parameter bit SIGNED     = 1'b1,
    localparam int L         = clog2(NUM_INPUTS),
    localparam int SW        = DATA_WIDTH + L
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data,
    input  logic                             valid,
    input  logic                             last,
    output logic [SW-1:0]                    sum,
    output logic                             sum_valid,
    output logic                             sum_last
);

    // Tree is built over the next power of two; missing leaves are zero.
    localparam int P = 1 << L;

    logic [L-1:0] vld_q;
    logic [L-1:0] last_q;

    for (genvar l = 0; l <= L; l++) begin : g_lvl
        logic [SW-1:0] node [P >> l];

        if (l == 0) begin : g_leaf
            for (genvar j = 0; j < P; j++) begin : g_in
                if (j < NUM_INPUTS) begin : g_used
                    logic [DATA_WIDTH-1:0] x;
                    assign x       = data[j*DATA_WIDTH +: DATA_WIDTH];
                    // Extend once at the leaves so every layer adds at full width.
                    assign node[j] = {{L{SIGNED & x[DATA_WIDTH-1]}}, x};
                end else begin : g_pad
                    assign node[j] = '0;
                end
            end
        end else begin : g_add
            for (genvar j = 0; j < (P >> l); j++) begin : g_pair
                logic [SW-1:0] q;
                always_ff @(posedge clk) begin
                    q <= g_lvl[l-1].node[2*j] + g_lvl[l-1].node[2*j+1];
                end
                assign node[j] = q;
            end
        end
    end

    assign sum = g_lvl[L].node[0];

    // Only the sideband is reset; sum data is qualified by sum_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            vld_q  <= (vld_q << 1)  | L'(valid);
            last_q <= (last_q << 1) | L'(valid & last);
        end
    end

    assign sum_valid = vld_q[L-1];
    assign sum_last  = last_q[L-1];

endmodule

// File: rtl/macc_stream_acc.sv
// Purpose: streaming dot-product engine; per-beat products summed, accumulated per vector, saturated.
// Latency: clog2(NUM_INPUTS)+2 cycles from a last beat being presented to the o_valid pulse.
// Backpressure: none; a beat is accepted on every cycle with i_valid high.
// Ports: clk, rst_n (sync, active-low); i_data_a/i_data_b packed operand vectors,
//        i_valid/i_last beat qualifiers; o_data (saturated result), o_valid (1-cycle pulse),
//        o_overflow (clamp seen in vector), o_beats (beats in vector, saturating).
module macc_stream_acc
    import macc_stream_acc_pkg::*;
#(
    parameter int NUM_INPUTS = 20,
    parameter int DATA_WIDTH = 8,
    parameter bit SIGNED     = 1'b1,
    parameter int ACC_WIDTH  = 32,
    parameter int BEAT_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DATA_WIDTH*NUM_INPUTS-1:0] i_data_a,
    input  logic [DATA_WIDTH*NUM_INPUTS-1:0] i_data_b,
    input  logic                             i_valid,
    input  logic                             i_last,
    output logic [ACC_WIDTH-1:0]             o_data,
    output logic                             o_valid,
    output logic                             o_overflow,
    output logic [BEAT_WIDTH-1:0]            o_beats
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int TW = tree_width(DATA_WIDTH, NUM_INPUTS);
    localparam int EW = ACC_WIDTH + 1;   // one guard bit catches any single-add overflow

    // ---------------- stage 0: products ----------------
    logic [NUM_INPUTS*PW-1:0] prod;
    logic [NUM_INPUTS*PW-1:0] prod_q;
    logic                     prod_vld;
    logic                     prod_last;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_mul
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [PW-1:0]         a_ext;
        logic [PW-1:0]         b_ext;
        (* use_dsp = "yes" *) logic [PW-1:0] p;

        assign a     = i_data_a[i*DATA_WIDTH +: DATA_WIDTH];
        assign b     = i_data_b[i*DATA_WIDTH +: DATA_WIDTH];
        // Low PW bits of the extended product are exact for both signednesses.
        assign a_ext = {{DATA_WIDTH{SIGNED & a[DATA_WIDTH-1]}}, a};
        assign b_ext = {{DATA_WIDTH{SIGNED & b[DATA_WIDTH-1]}}, b};
        assign p     = a_ext * b_ext;
        assign prod[i*PW +: PW] = p;
    end

    always_ff @(posedge clk) begin
        if (i_valid) begin
            prod_q <= prod;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_vld  <= 1'b0;
            prod_last <= 1'b0;
        end else begin
            prod_vld  <= i_valid;
            prod_last <= i_valid & i_last;
        end
    end

    // ---------------- stages 1..L: adder tree ----------------
    logic [TW-1:0] tree_sum;
    logic          tree_vld;
    logic          tree_last;

    macc_stream_acc_adder_tree #(
        .NUM_INPUTS (NUM_INPUTS),
        .DATA_WIDTH (PW),
        .SIGNED     (SIGNED)
    ) u_tree (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (prod_q),
        .valid     (prod_vld),
        .last      (prod_last),
        .sum       (tree_sum),
        .sum_valid (tree_vld),
        .sum_last  (tree_last)
    );

    // ---------------- stage L+1: accumulator ----------------
    acc_state_t             state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                   ovf_q, ovf_d;
    logic [BEAT_WIDTH-1:0]  beats_q, beats_d;
    logic [ACC_WIDTH-1:0]   out_data_d;
    logic                   out_vld_d, out_ovf_d;
    logic [BEAT_WIDTH-1:0]  out_beats_d;

    logic [EW-1:0]          sum_ext, acc_base, total;
    logic                   clamp;
    logic [ACC_WIDTH-1:0]   sat_val;
    logic [BEAT_WIDTH-1:0]  beats_inc;

    assign sum_ext  = {{(EW-TW){SIGNED & tree_sum[TW-1]}}, tree_sum};
    // An idle accumulator contributes nothing, so a new vector starts from the beat sum.
    assign acc_base = (state_q == ACC_OPEN) ? {SIGNED & acc_q[ACC_WIDTH-1], acc_q} : '0;
    assign total    = acc_base + sum_ext;

    always_comb begin
        clamp   = SIGNED ? (total[ACC_WIDTH] ^ total[ACC_WIDTH-1]) : total[ACC_WIDTH];
        sat_val = total[ACC_WIDTH-1:0];
        if (clamp) begin
            // Signed: guard bit gives the direction (1 = below min, 0 = above max).
            if (SIGNED) sat_val = {total[ACC_WIDTH], {(ACC_WIDTH-1){~total[ACC_WIDTH]}}};
            else        sat_val = '1;
        end
    end

    always_comb begin
        beats_inc = BEAT_WIDTH'(1);
        if (state_q == ACC_OPEN) begin
            beats_inc = (beats_q == '1) ? beats_q : beats_q + BEAT_WIDTH'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        beats_d     = beats_q;
        out_vld_d   = 1'b0;
        out_data_d  = o_data;
        out_ovf_d   = o_overflow;
        out_beats_d = o_beats;
        if (tree_vld) begin
            if (tree_last) begin
                out_vld_d   = 1'b1;
                out_data_d  = sat_val;
                out_ovf_d   = ovf_q | clamp;
                out_beats_d = beats_inc;
                state_d     = ACC_IDLE;
                acc_d       = '0;
                ovf_d       = 1'b0;
                beats_d     = '0;
            end else begin
                state_d     = ACC_OPEN;
                acc_d       = sat_val;   // a clamped value remains the base
                ovf_d       = ovf_q | clamp;
                beats_d     = beats_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ACC_IDLE;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            beats_q    <= '0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_overflow <= 1'b0;
            o_beats    <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            beats_q    <= beats_d;
            o_valid    <= out_vld_d;
            o_data     <= out_data_d;
            o_overflow <= out_ovf_d;
            o_beats    <= out_beats_d;
        end
    end

endmodule

// File: tb/tb_macc_stream_acc.sv
// Bench for macc_stream_acc: three instances (signed/32, signed/18, unsigned/32) share stimulus.
// Result pulses are recorded per instance and checked against constants or a reference model.
// Ports of every instance are fully connected; NUM_INPUTS=4, DATA_WIDTH=8.
module tb_macc_stream_acc;

    typedef struct packed {
        logic [63:0] data;
        logic        ovf;
        logic [15:0] beats;
        logic [31:0] cyc;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        valid;
    logic        last;

    logic [31:0] od0, od2;
    logic [17:0] od1;
    logic        ov0, ov1, ov2;
    logic        oo0, oo1, oo2;
    logic [15:0] ob0, ob1, ob2;

    int   cyc;
    int   n_cmp;
    int   n_fail;
    res_t obs [3][$];
    res_t expq[3][$];

    // Reference-model state per instance.
    bit     cfg_signed[3] = '{1'b1, 1'b1, 1'b0};
    int     cfg_aw[3]     = '{32, 18, 32};
    bit     m_open[3];
    longint m_acc[3];
    bit     m_ovf[3];
    int     m_beats[3];

    macc_stream_acc #(.NUM_INPUTS(4), .DATA_WIDTH(8), .SIGNED(1'b1), .ACC_WIDTH(32), .BEAT_WIDTH(16)) dut_s32 (
        .clk(clk), .rst_n(rst_n), .i_data_a(data_a), .i_data_b(data_b), .i_valid(valid), .i_last(last),
        .o_data(od0), .o_valid(ov0), .o_overflow(oo0), .o_beats(ob0));

    macc_stream_acc #(.NUM_INPUTS(4), .DATA_WIDTH(8), .SIGNED(1'b1), .ACC_WIDTH(18), .BEAT_WIDTH(16)) dut_s18 (
        .clk(clk), .rst_n(rst_n), .i_data_a(data_a), .i_data_b(data_b), .i_valid(valid), .i_last(last),
        .o_data(od1), .o_valid(ov1), .o_overflow(oo1), .o_beats(ob1));

    macc_stream_acc #(.NUM_INPUTS(4), .DATA_WIDTH(8), .SIGNED(1'b0), .ACC_WIDTH(32), .BEAT_WIDTH(16)) dut_u32 (
        .clk(clk), .rst_n(rst_n), .i_data_a(data_a), .i_data_b(data_b), .i_valid(valid), .i_last(last),
        .o_data(od2), .o_valid(ov2), .o_overflow(oo2), .o_beats(ob2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle with o_valid high, stamped with the cycle count.
    always @(negedge clk) begin : mon
        res_t r;
        if (ov0) begin
            r.data = 64'($signed(od0)); r.ovf = oo0; r.beats = ob0; r.cyc = 32'(cyc);
            obs[0].push_back(r);
        end
        if (ov1) begin
            r.data = 64'($signed(od1)); r.ovf = oo1; r.beats = ob1; r.cyc = 32'(cyc);
            obs[1].push_back(r);
        end
        if (ov2) begin
            r.data = 64'(od2); r.ovf = oo2; r.beats = ob2; r.cyc = 32'(cyc);
            obs[2].push_back(r);
        end
    end

    // Dot product of one beat, accumulated and clamped per vector as plain integers.
    function automatic void model_beat(input int d, input logic [31:0] a, input logic [31:0] b,
                                       input logic lst, input int at);
        longint s, acc, lo, hi, ea, eb;
        bit     clamp, ovf;
        int     beats;
        res_t   r;
        s = 0;
        clamp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ea = cfg_signed[d] ? longint'($signed(a[8*i +: 8])) : longint'(a[8*i +: 8]);
            eb = cfg_signed[d] ? longint'($signed(b[8*i +: 8])) : longint'(b[8*i +: 8]);
            s = s + ea * eb;
        end
        if (cfg_signed[d]) begin
            lo = -(64'sd1 <<< (cfg_aw[d] - 1));
            hi = (64'sd1 <<< (cfg_aw[d] - 1)) - 1;
        end else begin
            lo = 0;
            hi = (64'sd1 <<< cfg_aw[d]) - 1;
        end
        acc = (m_open[d] ? m_acc[d] : 64'sd0) + s;
        if (acc > hi) begin acc = hi; clamp = 1'b1; end
        else if (acc < lo) begin acc = lo; clamp = 1'b1; end
        ovf   = (m_open[d] && m_ovf[d]) || clamp;
        beats = m_open[d] ? ((m_beats[d] == 65535) ? 65535 : m_beats[d] + 1) : 1;
        if (lst) begin
            r.data = acc; r.ovf = ovf; r.beats = 16'(beats); r.cyc = 32'(at);
            expq[d].push_back(r);
            m_open[d] = 1'b0;
        end else begin
            m_open[d] = 1'b1; m_acc[d] = acc; m_ovf[d] = ovf; m_beats[d] = beats;
        end
    endfunction

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic drive_beat(input logic [31:0] a, input logic [31:0] b, input logic lst);
        data_a = a;
        data_b = b;
        valid  = 1'b1;
        last   = lst;
        for (int d = 0; d < 3; d++) model_beat(d, a, b, lst, cyc + 4);
        @(posedge clk); #1;
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) m_open[d] = 1'b0;
    endtask

    task automatic clear_queues();
        for (int d = 0; d < 3; d++) begin
            obs[d].delete();
            expq[d].delete();
        end
    endtask

    function automatic logic [31:0] rnd_vec();
        case ($urandom_range(0, 3))
            0:       return {4{8'h80}};
            1:       return {4{8'h7f}};
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        logic [31:0] got[12];
        rst_n = 1'b0; valid = 1'b0; last = 1'b0; data_a = '0; data_b = '0;
        for (int d = 0; d < 3; d++) m_open[d] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got = '{od0, 32'(od1), od2, 32'(ov0), 32'(ov1), 32'(ov2),
                32'(oo0), 32'(oo1), 32'(oo2), 32'(ob0), 32'(ob1), 32'(ob2)};
        for (int k = 0; k < 12; k++) begin
            n_cmp++;
            if (got[k] !== 32'd0) begin
                n_fail++;
                $display("FAIL reset output %0d: got %0d want 0", k, got[k]);
            end
        end
        rst_n = 1'b1;
        clear_queues();
        idle(6);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs[d].size() !== 0) begin
                n_fail++;
                $display("FAIL reset spurious pulse dut%0d: got %0d pulses want 0", d, obs[d].size());
            end
        end
    endtask

    task automatic test_single_beat();
        int   c;
        res_t e;
        clear_queues();
        c = cyc;
        drive_beat({4{8'd2}}, {4{8'd3}}, 1'b1);
        idle(8);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs[d].size() !== 1) begin
                n_fail++;
                $display("FAIL single_beat pulses dut%0d: got %0d want 1", d, obs[d].size());
            end else begin
                e = '{data: 64'd24, ovf: 1'b0, beats: 16'd1, cyc: 32'(c + 4)};
                n_cmp++;
                if (obs[d][0] !== e) begin
                    n_fail++;
                    $display("FAIL single_beat dut%0d: got data=%0d ovf=%0d beats=%0d cyc=%0d want data=%0d ovf=%0d beats=%0d cyc=%0d",
                             d, $signed(obs[d][0].data), obs[d][0].ovf, obs[d][0].beats, obs[d][0].cyc,
                             $signed(e.data), e.ovf, e.beats, e.cyc);
                end
            end
        end
        // Outputs hold after the pulse.
        n_cmp++;
        if (od0 !== 32'd24 || ob0 !== 16'd1 || ov0 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_beat hold: got data=%0d beats=%0d valid=%0d want 24/1/0", od0, ob0, ov0);
        end
    endtask

    task automatic test_gaps_signed();
        int     c;
        res_t   e;
        longint e_data[3] = '{196608, 131071, 196608};
        bit     e_ovf[3]  = '{1'b0, 1'b1, 1'b0};
        clear_queues();
        c = cyc;
        drive_beat({4{8'h80}}, {4{8'h80}}, 1'b0);
        idle(2);
        drive_beat({4{8'h80}}, {4{8'h80}}, 1'b0);
        idle(2);
        drive_beat({4{8'h80}}, {4{8'h80}}, 1'b1);
        idle(8);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs[d].size() !== 1) begin
                n_fail++;
                $display("FAIL gaps pulses dut%0d: got %0d want 1", d, obs[d].size());
            end else begin
                e = '{data: e_data[d], ovf: e_ovf[d], beats: 16'd3, cyc: 32'(c + 10)};
                n_cmp++;
                if (obs[d][0] !== e) begin
                    n_fail++;
                    $display("FAIL gaps dut%0d: got data=%0d ovf=%0d beats=%0d cyc=%0d want data=%0d ovf=%0d beats=%0d cyc=%0d",
                             d, $signed(obs[d][0].data), obs[d][0].ovf, obs[d][0].beats, obs[d][0].cyc,
                             $signed(e.data), e.ovf, e.beats, e.cyc);
                end
            end
        end
    endtask

    task automatic test_saturate();
        int     c;
        res_t   e;
        longint e_data[3][2] = '{'{131072, 4}, '{131071, 4}, '{131072, 4}};
        bit     e_ovf[3]     = '{1'b0, 1'b1, 1'b0};
        clear_queues();
        c = cyc;
        drive_beat({4{8'h80}}, {4{8'h80}}, 1'b0);
        drive_beat({4{8'h80}}, {4{8'h80}}, 1'b1);
        drive_beat({4{8'd1}},  {4{8'd1}},  1'b1);
        idle(8);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs[d].size() !== 2) begin
                n_fail++;
                $display("FAIL saturate pulses dut%0d: got %0d want 2", d, obs[d].size());
            end else begin
                for (int k = 0; k < 2; k++) begin
                    e = '{data: e_data[d][k], ovf: (k == 0) ? e_ovf[d] : 1'b0,
                          beats: (k == 0) ? 16'd2 : 16'd1, cyc: 32'(c + 5 + k)};
                    n_cmp++;
                    if (obs[d][k] !== e) begin
                        n_fail++;
                        $display("FAIL saturate dut%0d vec%0d: got data=%0d ovf=%0d beats=%0d cyc=%0d want data=%0d ovf=%0d beats=%0d cyc=%0d",
                                 d, k, $signed(obs[d][k].data), obs[d][k].ovf, obs[d][k].beats, obs[d][k].cyc,
                                 $signed(e.data), e.ovf, e.beats, e.cyc);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int     c;
        res_t   e;
        // 0xff is -1 when signed, 255 when unsigned.
        longint e_data[3][2] = '{'{4, 16}, '{4, 16}, '{260100, 16}};
        clear_queues();
        c = cyc;
        drive_beat({4{8'hff}}, {4{8'hff}}, 1'b1);
        drive_beat({4{8'd1}},  {4{8'd2}},  1'b0);
        drive_beat({4{8'd1}},  {4{8'd2}},  1'b1);
        idle(8);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs[d].size() !== 2) begin
                n_fail++;
                $display("FAIL back_to_back pulses dut%0d: got %0d want 2", d, obs[d].size());
            end else begin
                for (int k = 0; k < 2; k++) begin
                    // One idle cycle separates the two pulses.
                    e = '{data: e_data[d][k], ovf: 1'b0, beats: (k == 0) ? 16'd1 : 16'd2,
                          cyc: 32'(c + 4 + 2 * k)};
                    n_cmp++;
                    if (obs[d][k] !== e) begin
                        n_fail++;
                        $display("FAIL back_to_back dut%0d vec%0d: got data=%0d ovf=%0d beats=%0d cyc=%0d want data=%0d ovf=%0d beats=%0d cyc=%0d",
                                 d, k, $signed(obs[d][k].data), obs[d][k].ovf, obs[d][k].beats, obs[d][k].cyc,
                                 $signed(e.data), e.ovf, e.beats, e.cyc);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int   c;
        res_t e;
        clear_queues();
        drive_beat({4{8'd5}}, {4{8'd7}}, 1'b0);
        drive_beat({4{8'd5}}, {4{8'd7}}, 1'b0);
        do_reset(1);
        n_cmp++;
        if (od0 !== 32'd0 || ob0 !== 16'd0 || oo1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: got data=%0d beats=%0d ovf=%0d want 0/0/0", od0, ob0, oo1);
        end
        c = cyc;
        drive_beat({4{8'd1}}, {4{8'd1}}, 1'b1);
        idle(8);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs[d].size() !== 1) begin
                n_fail++;
                $display("FAIL reset_mid pulses dut%0d: got %0d want 1", d, obs[d].size());
            end else begin
                e = '{data: 64'd4, ovf: 1'b0, beats: 16'd1, cyc: 32'(c + 4)};
                n_cmp++;
                if (obs[d][0] !== e) begin
                    n_fail++;
                    $display("FAIL reset_mid dut%0d: got data=%0d ovf=%0d beats=%0d cyc=%0d want data=%0d ovf=%0d beats=%0d cyc=%0d",
                             d, $signed(obs[d][0].data), obs[d][0].ovf, obs[d][0].beats, obs[d][0].cyc,
                             $signed(e.data), e.ovf, e.beats, e.cyc);
                end
            end
        end
    endtask

    task automatic test_random();
        int   len;
        res_t o, e;
        clear_queues();
        for (int v = 0; v < 60; v++) begin
            len = $urandom_range(1, 5);
            for (int k = 0; k < len; k++) begin
                drive_beat(rnd_vec(), rnd_vec(), k == len - 1);
                idle($urandom_range(0, 2));
            end
        end
        idle(10);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs[d].size() !== expq[d].size()) begin
                n_fail++;
                $display("FAIL random pulses dut%0d: got %0d want %0d", d, obs[d].size(), expq[d].size());
            end
            while (obs[d].size() > 0 && expq[d].size() > 0) begin
                o = obs[d].pop_front();
                e = expq[d].pop_front();
                n_cmp++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL random dut%0d: got data=%0d ovf=%0d beats=%0d cyc=%0d want data=%0d ovf=%0d beats=%0d cyc=%0d",
                             d, $signed(o.data), o.ovf, o.beats, o.cyc, $signed(e.data), e.ovf, e.beats, e.cyc);
                end
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_single_beat();
        test_gaps_signed();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
